writeback_stage: RTL and testbench

Final pipeline stage of the risky2 core. Accepts the memory-stage pipe register, selects ALU result or load data, performs load byte/halfword extraction with sign/zero extension, and drives the register-file write port that the decode stage consumes (`wEnable`/`rdAddr`/`wData`) along with `pc_WB`. Owns the halt-drain state machine and an optional retired-instruction counter.

---
 rtl/writeback_stage.sv | 148 ++++++++++++++
 tb/tb_writeback_stage.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage. Selects the ALU result or extracted
// load data, drives the register-file write port and pc_WB, and runs the
// RUN -> DRAIN -> HALTED halt sequence.
// Optional feature macro: WB_RETIRE_COUNT_EN (adds the 32-bit retire counter;
// when undefined, retire_count is constant 0).
module writeback_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] in_pc,
   input  logic [4:0]  in_rd_addr,
   input  logic        in_w_enable,
   input  logic        in_is_load,
   input  logic [2:0]  in_funct3,
   input  logic [1:0]  in_addr_low,
   input  logic [31:0] in_alu_result,
   input  logic [31:0] in_mem_rdata,
   input  logic        in_is_halt,
   output logic        wb_w_enable,
   output logic [4:0]  wb_rd_addr,
   output logic [31:0] wb_w_data,
   output logic [31:0] pc_WB,
   output logic        halted,
   output logic [31:0] retire_count
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        accept;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_data;
   logic [31:0] w_data_sel;

   logic        w_enable_q, w_enable_d;
   logic [4:0]  rd_addr_q, rd_addr_d;
   logic [31:0] w_data_q, w_data_d;
   logic [31:0] pc_q, pc_d;
   logic        halted_q, halted_d;

   // Only real instructions arriving while running are taken into writeback.
   assign accept = in_valid && (state_q == ST_RUN);

   // Load lane selection and sign/zero extension; unknown codes pass the word.
   always_comb begin
      byte_sel  = 8'h00;
      half_sel  = in_addr_low[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];
      load_data = in_mem_rdata;
      case (in_addr_low)
         2'd0:    byte_sel = in_mem_rdata[7:0];
         2'd1:    byte_sel = in_mem_rdata[15:8];
         2'd2:    byte_sel = in_mem_rdata[23:16];
         default: byte_sel = in_mem_rdata[31:24];
      endcase
      case (in_funct3)
         3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  load_data = {24'h000000, byte_sel};
         3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_data = {16'h0000, half_sel};
         default: load_data = in_mem_rdata;
      endcase
      w_data_sel = in_is_load ? load_data : in_alu_result;
   end

   // Next-state and next-output logic; rd/data/pc hold unless an entry is accepted.
   always_comb begin
      state_d    = state_q;
      w_enable_d = 1'b0;
      rd_addr_d  = rd_addr_q;
      w_data_d   = w_data_q;
      pc_d       = pc_q;
      halted_d   = halted_q;
      case (state_q)
         ST_RUN: begin
            if (accept) begin
               rd_addr_d  = in_rd_addr;
               w_data_d   = w_data_sel;
               pc_d       = in_pc;
               w_enable_d = in_w_enable && (in_rd_addr != 5'd0) && !in_is_halt;
               if (in_is_halt) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            // One quiet cycle, then the core reports halted.
            state_d  = ST_HALTED;
            halted_d = 1'b1;
         end
         default: begin
            state_d  = ST_HALTED;
            halted_d = 1'b1;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_RUN;
         w_enable_q <= 1'b0;
         rd_addr_q  <= 5'd0;
         w_data_q   <= 32'd0;
         pc_q       <= 32'd0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         w_enable_q <= w_enable_d;
         rd_addr_q  <= rd_addr_d;
         w_data_q   <= w_data_d;
         pc_q       <= pc_d;
         halted_q   <= halted_d;
      end
   end

   assign wb_w_enable = w_enable_q;
   assign wb_rd_addr  = rd_addr_q;
   assign wb_w_data   = w_data_q;
   assign pc_WB       = pc_q;
   assign halted      = halted_q;

`ifdef WB_RETIRE_COUNT_EN
   logic [31:0] retire_q, retire_d;

   always_comb begin
      retire_d = accept ? retire_q + 32'd1 : retire_q;
   end

   // Retire counter; wraps silently, visible together with the entry's outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         retire_q <= 32'd0;
      end else begin
         retire_q <= retire_d;
      end
   end

   assign retire_count = retire_q;
`else
   assign retire_count = 32'd0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Testbench for writeback_stage: directed scenarios plus randomized entries
// checked against a behavioural model of the writeback rules.
module tb_writeback_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_pc = '0;
   logic [4:0]  in_rd_addr = '0;
   logic        in_w_enable = 1'b0;
   logic        in_is_load = 1'b0;
   logic [2:0]  in_funct3 = '0;
   logic [1:0]  in_addr_low = '0;
   logic [31:0] in_alu_result = '0;
   logic [31:0] in_mem_rdata = '0;
   logic        in_is_halt = 1'b0;
   logic        wb_w_enable;
   logic [4:0]  wb_rd_addr;
   logic [31:0] wb_w_data;
   logic [31:0] pc_WB;
   logic        halted;
   logic [31:0] retire_count;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state
   logic        m_we, m_halted, m_pending, m_stopped;
   logic [4:0]  m_rd;
   logic [31:0] m_data, m_pc, m_cnt;

   writeback_stage dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_pc(in_pc), .in_rd_addr(in_rd_addr),
      .in_w_enable(in_w_enable), .in_is_load(in_is_load), .in_funct3(in_funct3),
      .in_addr_low(in_addr_low), .in_alu_result(in_alu_result),
      .in_mem_rdata(in_mem_rdata), .in_is_halt(in_is_halt),
      .wb_w_enable(wb_w_enable), .wb_rd_addr(wb_rd_addr), .wb_w_data(wb_w_data),
      .pc_WB(pc_WB), .halted(halted), .retire_count(retire_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] exp_count();
`ifdef WB_RETIRE_COUNT_EN
      return m_cnt;
`else
      return 32'd0;
`endif
   endfunction

   // Load result from the instruction's width/sign rules, using shifts.
   function automatic logic [31:0] model_load(logic [2:0] f3, logic [1:0] al, logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(w >> (8 * al));
      h = 16'(w >> (16 * al[1]));
      case (f3)
         3'd0: return {{24{b[7]}}, b};
         3'd4: return {24'd0, b};
         3'd1: return {{16{h[15]}}, h};
         3'd5: return {16'd0, h};
         default: return w;
      endcase
   endfunction

   function automatic void model_reset();
      m_we = 0; m_rd = 0; m_data = 0; m_pc = 0;
      m_halted = 0; m_pending = 0; m_stopped = 0; m_cnt = 0;
   endfunction

   // One clock of the architectural behaviour.
   function automatic void model_step();
      m_we = 0;
      if (m_pending) begin
         m_halted  = 1;
         m_pending = 0;
      end
      if (in_valid && !m_stopped) begin
         m_pc   = in_pc;
         m_rd   = in_rd_addr;
         m_data = in_is_load ? model_load(in_funct3, in_addr_low, in_mem_rdata) : in_alu_result;
         m_we   = in_w_enable && (in_rd_addr != 0) && !in_is_halt;
         m_cnt  = m_cnt + 1;
         if (in_is_halt) begin
            m_stopped = 1;
            m_pending = 1;
         end
      end
   endfunction

   task automatic set_in(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                         input logic we, input logic ld, input logic [2:0] f3,
                         input logic [1:0] al, input logic [31:0] alu,
                         input logic [31:0] mem, input logic hlt);
      in_valid = v; in_pc = pc; in_rd_addr = rd; in_w_enable = we; in_is_load = ld;
      in_funct3 = f3; in_addr_low = al; in_alu_result = alu; in_mem_rdata = mem;
      in_is_halt = hlt;
   endtask

   // Present current inputs for one posedge, update model, land on negedge.
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++;
      if ({wb_w_enable, wb_rd_addr, wb_w_data, pc_WB, halted, retire_count} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: we=%0b rd=%0d data=%h pc=%h halted=%0b cnt=%0d, expected all 0",
                  wb_w_enable, wb_rd_addr, wb_w_data, pc_WB, halted, retire_count);
      end
   endtask

   task automatic test_alu_write();
      set_in(1, 32'h0000_0100, 5, 1, 0, 0, 0, 32'h1234_5678, 32'hDEAD_BEEF, 0);
      cycle();
      n_checks++;
      if ({wb_w_enable, wb_rd_addr, wb_w_data, pc_WB} !== {1'b1, 5'd5, 32'h1234_5678, 32'h0000_0100}) begin
         n_fail++;
         $display("FAIL alu_write: we=%0b rd=%0d data=%h pc=%h, expected 1 5 12345678 00000100",
                  wb_w_enable, wb_rd_addr, wb_w_data, pc_WB);
      end
      $display("alu_write: rd=%0d data=%h pc=%h", wb_rd_addr, wb_w_data, pc_WB);
   endtask

   task automatic test_loads();
      logic [2:0]  f3s [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
      logic [1:0]  als [5] = '{2'd2, 2'd3, 2'd0, 2'd2, 2'd1};
      logic [31:0] exps[5] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'h0000_7F01, 32'h0000_80FF, 32'h80FF_7F01};
      for (int i = 0; i < 5; i++) begin
         set_in(1, 32'h200 + 4 * i, 5'(10 + i), 1, 1, f3s[i], als[i], 32'h5555_5555, 32'h80FF_7F01, 0);
         cycle();
         n_checks++;
         if (wb_w_data !== exps[i] || wb_w_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL load_f3_%0d: data=%h we=%0b, expected %h we=1", f3s[i], wb_w_data, wb_w_enable, exps[i]);
         end
         $display("load f3=%0d addr_low=%0d data=%h", f3s[i], als[i], wb_w_data);
      end
   endtask

   task automatic test_x0_bubble();
      logic [31:0] cnt_before;
      set_in(1, 32'h300, 0, 1, 0, 0, 0, 32'hAAAA_0000, 0, 0);
      cycle();
      n_checks++;
      if (wb_w_enable !== 1'b0 || pc_WB !== 32'h300) begin
         n_fail++;
         $display("FAIL x0_write: we=%0b pc=%h, expected we=0 pc=00000300", wb_w_enable, pc_WB);
      end
      cnt_before = exp_count();
      set_in(0, 32'h999, 7, 1, 0, 0, 0, 32'h1111_1111, 0, 0);
      cycle();
      n_checks++;
      if (wb_w_enable !== 1'b0 || pc_WB !== 32'h300 || wb_rd_addr !== 5'd0 ||
          wb_w_data !== 32'hAAAA_0000 || retire_count !== cnt_before) begin
         n_fail++;
         $display("FAIL bubble: we=%0b pc=%h rd=%0d data=%h cnt=%0d, expected 0 00000300 0 aaaa0000 %0d",
                  wb_w_enable, pc_WB, wb_rd_addr, wb_w_data, retire_count, cnt_before);
      end
      $display("x0/bubble: pc=%h cnt=%0d", pc_WB, retire_count);
   endtask

   task automatic test_random();
      for (int i = 0; i < 200; i++) begin
         set_in(($urandom_range(0, 4) != 0), $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
                3'($urandom), 2'($urandom), $urandom, $urandom, 0);
         cycle();
         n_checks++;
         if (wb_w_enable !== m_we || wb_rd_addr !== m_rd || wb_w_data !== m_data ||
             pc_WB !== m_pc || halted !== m_halted || retire_count !== exp_count()) begin
            n_fail++;
            $display("FAIL random_%0d: got we=%0b rd=%0d data=%h pc=%h h=%0b cnt=%0d exp we=%0b rd=%0d data=%h pc=%h h=%0b cnt=%0d",
                     i, wb_w_enable, wb_rd_addr, wb_w_data, pc_WB, halted, retire_count,
                     m_we, m_rd, m_data, m_pc, m_halted, exp_count());
         end
      end
      $display("random: 200 entries, retire_count=%0d", retire_count);
   endtask

   task automatic test_counter();
      int valids = 0;
      apply_reset();
      for (int i = 0; i < 13; i++) begin
         logic v;
         v = !(i == 2 || i == 6 || i == 11);
         set_in(v, 32'h400 + 4 * i, 5'(i + 1), 1, 0, 0, 0, 32'(i), 0, 0);
         cycle();
         if (v) valids++;
      end
      n_checks++;
`ifdef WB_RETIRE_COUNT_EN
      if (retire_count !== 32'(valids) || retire_count !== exp_count()) begin
`else
      if (retire_count !== 32'd0) begin
`endif
         n_fail++;
         $display("FAIL counter: retire_count=%0d, expected %0d", retire_count, exp_count());
      end
      $display("counter: retire_count=%0d after %0d valid entries", retire_count, valids);
   endtask

   task automatic test_halt();
      logic [31:0] cnt_frozen;
      apply_reset();
      set_in(1, 32'h500, 3, 1, 0, 0, 0, 32'h33, 0, 0);
      cycle();
      set_in(1, 32'h504, 7, 1, 0, 0, 0, 32'h77, 0, 1);  // halt with w_enable
      cycle();
      n_checks++;
      if (wb_w_enable !== 1'b0 || halted !== 1'b0 || pc_WB !== 32'h504) begin
         n_fail++;
         $display("FAIL halt_cycle1: we=%0b halted=%0b pc=%h, expected 0 0 00000504", wb_w_enable, halted, pc_WB);
      end
      set_in(1, 32'h508, 9, 1, 0, 0, 0, 32'h99, 0, 0);
      cycle();
      n_checks++;
      if (wb_w_enable !== 1'b0 || halted !== 1'b1 || pc_WB !== 32'h504) begin
         n_fail++;
         $display("FAIL halt_cycle2: we=%0b halted=%0b pc=%h, expected 0 1 00000504", wb_w_enable, halted, pc_WB);
      end
      cnt_frozen = exp_count();
      for (int i = 0; i < 4; i++) begin
         set_in(1, 32'h600 + 4 * i, 5'(i + 1), 1, 0, 0, 0, $urandom, 0, 0);
         cycle();
         n_checks++;
         if (wb_w_enable !== 1'b0 || halted !== 1'b1 || pc_WB !== 32'h504 || retire_count !== cnt_frozen) begin
            n_fail++;
            $display("FAIL halted_ignore_%0d: we=%0b halted=%0b pc=%h cnt=%0d, expected 0 1 00000504 %0d",
                     i, wb_w_enable, halted, pc_WB, retire_count, cnt_frozen);
         end
      end
      $display("halt: halted=%0b pc=%h cnt=%0d", halted, pc_WB, retire_count);
   endtask

   task automatic test_reset_mid_drain();
      apply_reset();
      set_in(1, 32'h700, 4, 1, 0, 0, 0, 32'h44, 0, 1);
      cycle();                 // now in DRAIN
      #1 rst = 1'b0;
      #1;
      n_checks++;
      if ({wb_w_enable, wb_rd_addr, wb_w_data, pc_WB, halted, retire_count} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_drain: we=%0b rd=%0d data=%h pc=%h halted=%0b cnt=%0d, expected all 0",
                  wb_w_enable, wb_rd_addr, wb_w_data, pc_WB, halted, retire_count);
      end
      set_in(1, 32'h710, 8, 1, 0, 0, 0, 32'h88, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      cycle();
      n_checks++;
      if ({wb_w_enable, wb_rd_addr, wb_w_data, pc_WB, halted} !== {1'b1, 5'd8, 32'h88, 32'h710, 1'b0} ||
          retire_count !== exp_count()) begin
         n_fail++;
         $display("FAIL after_reset_write: we=%0b rd=%0d data=%h pc=%h halted=%0b cnt=%0d, expected 1 8 00000088 00000710 0 %0d",
                  wb_w_enable, wb_rd_addr, wb_w_data, pc_WB, halted, retire_count, exp_count());
      end
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) cycle();
      n_checks++;
      if (halted !== 1'b0) begin
         n_fail++;
         $display("FAIL halted_stays_low: halted=%0b, expected 0", halted);
      end
      $display("reset_mid_drain: pc=%h halted=%0b", pc_WB, halted);
   endtask

   initial begin
      model_reset();
      test_reset();
      test_alu_write();
      test_loads();
      test_x0_bubble();
      test_random();
      test_counter();
      test_halt();
      test_reset_mid_drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
